// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default frame geometry
// common to both link ends, and a counter-width helper.
package uart_pkg;

    localparam int DEFAULT_WORD_SIZE  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: CLK_DIV clocks per baud tick, OVERSAMPLE ticks per bit.
// Clear restarts the bit period so the next bit lasts a full CLK_DIV*OVERSAMPLE.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic clk,
    input  logic r_reset,
    input  logic clear,
    input  logic enable,
    output logic baud_tick,
    output logic bit_end
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int OS_W  = cnt_width(OVERSAMPLE);

    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  os_cnt;

    assign baud_tick = enable && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_end   = baud_tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (r_reset || clear) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (enable) begin
            if (baud_tick) begin
                div_cnt <= '0;
                os_cnt  <= bit_end ? '0 : os_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, WORD_SIZE data bits LSB first, optional parity,
// STOP_BITS stop bits. tx_serial is registered; tx_done/tx_ready overlap on the
// last stop-bit clock so a held tx_valid chains frames with no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WORD_SIZE  = DEFAULT_WORD_SIZE,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int CLK_DIV    = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 r_reset,
    input  logic                 tx_valid,
    input  logic [WORD_SIZE-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // One counter serves both the data bits and the stop bits.
    localparam int BIT_W = cnt_width((WORD_SIZE > STOP_BITS) ? WORD_SIZE : STOP_BITS);

    tx_state_t            state, state_next;
    logic [WORD_SIZE-1:0] shreg, shreg_next;
    logic                 parity_bit, parity_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic                 serial_next;
    logic                 accept;
    logic                 baud_tick, bit_end, bit_done;
    logic                 last_data, last_stop;

    uart_baud_gen #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud_gen (
        .clk       (clk),
        .r_reset   (r_reset),
        .clear     (accept),
        .enable    (tx_busy),
        .baud_tick (baud_tick),
        .bit_end   (bit_end)
    );

    assign bit_done  = baud_tick && bit_end;
    assign last_data = (bit_cnt == BIT_W'(WORD_SIZE - 1));
    assign last_stop = (bit_cnt == BIT_W'(STOP_BITS - 1));

    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == STOP) && bit_done && last_stop;
    assign tx_ready = (state == IDLE) || tx_done;
    assign accept   = tx_valid && tx_ready;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        parity_next  = parity_bit;
        bit_cnt_next = bit_cnt;
        serial_next  = tx_serial;

        case (state)
            IDLE: serial_next = 1'b1;
            START: begin
                if (bit_done) begin
                    state_next  = DATA;
                    serial_next = shreg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    shreg_next = shreg >> 1;
                    if (last_data) begin
                        bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            state_next  = PARITY;
                            serial_next = parity_bit;
                        end else begin
                            state_next  = STOP;
                            serial_next = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        serial_next  = shreg_next[0];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_next  = STOP;
                    serial_next = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (last_stop) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                    serial_next = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                serial_next = 1'b1;
            end
        endcase

        // Acceptance happens from IDLE or on the tx_done cycle; either way it
        // loads the word and starts the start bit on the next clock.
        if (accept) begin
            state_next   = START;
            shreg_next   = tx_data;
            parity_next  = (^tx_data) ^ (PARITY_ODD != 0);
            bit_cnt_next = '0;
            serial_next  = 1'b0;
        end
    end

    // NOTE: the shift register is a plain register, not a memory, so it is
    // cleared on reset along with the rest of the datapath.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            state      <= IDLE;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            tx_serial  <= 1'b1;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            bit_cnt    <= bit_cnt_next;
            tx_serial  <= serial_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 8O1) at 32 clocks per bit,
// checked against a frame model built from the bit list and a mid-bit decoder.
module tb_uart_tx;

    localparam int NDUT = 3;
    localparam int CDIV = 2;
    localparam int OSMP = 16;
    localparam int N    = CDIV * OSMP;
    localparam int PEN  [NDUT] = '{0, 1, 1};
    localparam int PODD [NDUT] = '{0, 0, 1};
    localparam int SB   [NDUT] = '{1, 2, 1};

    logic       clk;
    logic       r_reset;
    logic       tx_valid  [NDUT];
    logic [7:0] tx_data   [NDUT];
    logic       tx_ready  [NDUT];
    logic       tx_serial [NDUT];
    logic       tx_busy   [NDUT];
    logic       tx_done   [NDUT];

    int checks = 0;
    int errors = 0;
    int done_cnt [NDUT] = '{default: 0};
    logic [7:0] rx_q [$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        uart_tx #(
            .WORD_SIZE  (8),
            .OVERSAMPLE (OSMP),
            .CLK_DIV    (CDIV),
            .PARITY_EN  (PEN[g]),
            .PARITY_ODD (PODD[g]),
            .STOP_BITS  (SB[g])
        ) u_dut (
            .clk       (clk),
            .r_reset   (r_reset),
            .tx_valid  (tx_valid[g]),
            .tx_data   (tx_data[g]),
            .tx_ready  (tx_ready[g]),
            .tx_serial (tx_serial[g]),
            .tx_busy   (tx_busy[g]),
            .tx_done   (tx_done[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++)
            if (tx_done[k] === 1'b1) done_cnt[k]++;
    end

    // Independent receiver on DUT 0: centre-samples each bit after a falling edge.
    initial begin : rx_model
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (tx_serial[0] === 1'b0) begin
                repeat (N / 2) @(negedge clk);
                if (tx_serial[0] === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (N) @(negedge clk);
                        b[i] = tx_serial[0];
                    end
                    repeat (N) @(negedge clk);
                    if (tx_serial[0] === 1'b1) rx_q.push_back(b);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_check(input int k);
        check($sformatf("idle_serial%0d", k), 32'(tx_serial[k]), 1);
        check($sformatf("idle_ready%0d", k),  32'(tx_ready[k]),  1);
        check($sformatf("idle_busy%0d", k),   32'(tx_busy[k]),   0);
        check($sformatf("idle_done%0d", k),   32'(tx_done[k]),   0);
    endtask

    // Present a word and wait (bounded) for the accepting edge; returns at the
    // negedge of the first start-bit clock.
    task automatic start_frame(input int k, input logic [7:0] d);
        int waited = 0;
        tx_valid[k] = 1'b1;
        tx_data[k]  = d;
        while (tx_ready[k] !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("accept_ready%0d", k), 32'(tx_ready[k]), 1);
        @(negedge clk);
    endtask

    // Check one whole frame clock by clock against the expected bit list.
    // With hold set, tx_valid stays high carrying nxt so it is taken on tx_done.
    task automatic run_frame(input int k, input logic [7:0] d, input bit hold,
                             input logic [7:0] nxt, output logic [15:0] seen);
        int   nb = 1 + 8 + PEN[k] + SB[k];
        int   len = nb * N;
        bit   exp_bits [$];
        int   good [16];
        int   done_n = 0, done_pos = -1, rdy_n = 0, rdy_pos = -1, busy_n = 0;
        int   b;
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(((d >> i) & 8'd1) != 0);
        if (PEN[k] != 0) exp_bits.push_back((($countones(d) % 2) != 0) ^ (PODD[k] != 0));
        for (int i = 0; i < SB[k]; i++) exp_bits.push_back(1'b1);
        foreach (good[i]) good[i] = 0;
        seen = '0;
        for (int c = 0; c < len; c++) begin
            if (c > 0) @(negedge clk);
            b = c / N;
            if (tx_serial[k] === exp_bits[b]) good[b]++;
            if (c % N == N / 2) seen[b] = tx_serial[k];
            if (tx_done[k] === 1'b1) begin done_n++; done_pos = c; end
            if (tx_ready[k] === 1'b1) begin rdy_n++; rdy_pos = c; end
            if (tx_busy[k] === 1'b1) busy_n++;
            if (c == 0) begin
                tx_valid[k] = hold;
                tx_data[k]  = nxt;
            end
        end
        for (int i = 0; i < nb; i++)
            check($sformatf("dut%0d_bit%0d_clocks", k, i), good[i], N);
        check($sformatf("dut%0d_done_count", k), done_n, 1);
        check($sformatf("dut%0d_done_pos", k), done_pos, len - 1);
        check($sformatf("dut%0d_ready_count", k), rdy_n, 1);
        check($sformatf("dut%0d_ready_pos", k), rdy_pos, len - 1);
        check($sformatf("dut%0d_busy_clocks", k), busy_n, len);
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [7:0] data;
        logic       serial;
        logic       ready;
        logic       busy;
        logic       done;
    } vec_t;

    initial begin
        vec_t       vecs [8];
        logic [15:0] seen;
        logic [7:0] d, nxt;
        bit         h;
        int         snap;

        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

        r_reset = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end

        // Reset, acceptance latency, reset-over-valid and reset abandoning a frame.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            r_reset     = vecs[i].rst;
            tx_valid[0] = vecs[i].valid;
            tx_data[0]  = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_serial", i), 32'(tx_serial[0]), 32'(vecs[i].serial));
            check($sformatf("vec%0d_ready", i),  32'(tx_ready[0]),  32'(vecs[i].ready));
            check($sformatf("vec%0d_busy", i),   32'(tx_busy[0]),   32'(vecs[i].busy));
            check($sformatf("vec%0d_done", i),   32'(tx_done[0]),   32'(vecs[i].done));
        end
        tx_valid[0] = 1'b0;
        repeat (N * 12) @(negedge clk);

        // Single 8N1 frame of 0xA5.
        start_frame(0, 8'hA5);
        run_frame(0, 8'hA5, 1'b0, 8'h00, seen);
        check("a5_bit_pattern", 32'(seen[9:0]), 32'b1101001010);
        @(negedge clk);
        idle_check(0);

        // Parity bits.
        start_frame(1, 8'hA5);
        run_frame(1, 8'hA5, 1'b0, 8'h00, seen);
        check("a5_even_parity", 32'(seen[9]), 0);
        @(negedge clk);
        start_frame(1, 8'h01);
        run_frame(1, 8'h01, 1'b0, 8'h00, seen);
        check("01_even_parity", 32'(seen[9]), 1);
        @(negedge clk);
        start_frame(2, 8'hA5);
        run_frame(2, 8'hA5, 1'b0, 8'h00, seen);
        check("a5_odd_parity", 32'(seen[9]), 1);
        @(negedge clk);
        idle_check(2);

        // Back-to-back with two stop bits: next start right after tx_done.
        start_frame(1, 8'h00);
        run_frame(1, 8'h00, 1'b1, 8'hFF, seen);
        @(negedge clk);
        run_frame(1, 8'hFF, 1'b0, 8'h00, seen);
        @(negedge clk);
        idle_check(1);

        // Reset during data bit 3 of 0x55.
        snap = done_cnt[0];
        start_frame(0, 8'h55);
        tx_valid[0] = 1'b0;
        repeat (4 * N + 10) @(negedge clk);
        r_reset = 1'b1;
        @(negedge clk);
        r_reset = 1'b0;
        idle_check(0);
        repeat (N * 12) @(negedge clk);
        check("reset_no_done", done_cnt[0], snap);
        start_frame(0, 8'h55);
        run_frame(0, 8'h55, 1'b0, 8'h00, seen);
        check("55_after_reset", 32'(seen[8:1]), 32'h55);
        @(negedge clk);

        // Loopback through the bench receiver, frames chained.
        rx_q.delete();
        start_frame(0, 8'h00);
        run_frame(0, 8'h00, 1'b1, 8'hFF, seen);
        @(negedge clk);
        run_frame(0, 8'hFF, 1'b1, 8'h3C, seen);
        @(negedge clk);
        run_frame(0, 8'h3C, 1'b0, 8'h00, seen);
        repeat (20) @(negedge clk);
        check("rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("rx_byte0", 32'(rx_q[0]), 32'h00);
            check("rx_byte1", 32'(rx_q[1]), 32'hFF);
            check("rx_byte2", 32'(rx_q[2]), 32'h3C);
        end

        // Random words on every configuration, randomly chained or spaced.
        for (int k = 0; k < NDUT; k++) begin
            d = 8'($urandom);
            start_frame(k, d);
            for (int i = 0; i < 4; i++) begin
                nxt = 8'($urandom);
                h   = (i < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
                run_frame(k, d, h, nxt, seen);
                check($sformatf("rand%0d_%0d_data", k, i), 32'(seen[8:1]), 32'(d));
                @(negedge clk);
                if (!h) begin
                    idle_check(k);
                    if (i < 3) start_frame(k, nxt);
                end
                d = nxt;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1-style UART transmitter. It serializes one parallel word per valid/ready handshake onto a single idle-high line.
- Bit timing is compatible with the team's 16x-oversampling UART receiver: one bit = CLK_DIV x OVERSAMPLE clocks.
- Sits between a byte producer (CPU/stream logic) and the TX pin. It pairs with the receiver on the far end of the link.

Parameters:
- WORD_SIZE, 8, data bits per frame.
- OVERSAMPLE, 16, baud ticks per bit (matches receiver sampling).
- CLK_DIV, 4, clocks per baud tick (must be >= 1).
- PARITY_EN, 0, 1 = append parity bit after data.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock, rising edge.
- r_reset  input  1  synchronous, active-high reset.
- tx_valid  input  1  producer has a word on tx_data.
- tx_data  input  WORD_SIZE  word to send, LSB transmitted first.
- tx_ready  output  1  block can accept a word this cycle.
- tx_serial  output  1  serial line, idle high.
- tx_busy  output  1  frame in progress (any state other than IDLE).
- tx_done  output  1  single-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (r_reset sampled high at a clock edge):
  - next-cycle values: tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, state = IDLE.
  - tick and bit counters cleared; shift register cleared.
  - Reset mid-frame abandons the frame: the line returns high on the next clock and no tx_done is issued.
- Handshake: a transfer occurs on a clock edge where tx_valid & tx_ready.
  - tx_data is captured into the shift register; parity is computed from the captured value.
  - tx_ready is high only in IDLE and deasserts the cycle after acceptance.
  - tx_data is don't-care when no transfer occurs.
- Timing:
  - The tick divider and oversample counter are zeroed on acceptance, so every bit lasts exactly CLK_DIV*OVERSAMPLE clocks.
  - The start bit drives tx_serial low in the cycle following acceptance (1-clock latency).
- State machine (tx_serial is registered):
  - IDLE: tx_serial = 1. On transfer -> START.
  - START: tx_serial = 0 for one bit period -> DATA.
  - DATA: tx_serial = shreg[0], shift right each bit period. Bit counter runs 0..WORD_SIZE-1. After the last bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: tx_serial = ^data XOR PARITY_ODD for one bit -> STOP.
  - STOP: tx_serial = 1 for STOP_BITS bit periods.
    - At the end of the final stop bit: -> IDLE, tx_done = 1 for exactly that cycle, tx_ready = 1 in the same cycle.
- Back-to-back frames: tx_valid held high at the tx_done cycle is accepted that cycle. The next start bit follows with no extra idle clocks (stop-bit length preserved exactly).
- Frame length: (1 + WORD_SIZE + PARITY_EN + STOP_BITS) * CLK_DIV * OVERSAMPLE clocks from first start-bit clock to tx_done.
- Counter widths: $clog2 of the respective max value, minimum 1 bit. No wrap-around except the intended terminal-count rollover.
- Unused/illegal state encoding -> IDLE on the next clock with tx_serial = 1.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding.
  - default WORD_SIZE/OVERSAMPLE constants, shared with the receiver so both ends agree.
- Sub-module uart_baud_gen:
  - CLK_DIV x OVERSAMPLE tick counter with synchronous clear input.
  - outputs baud_tick and bit_end strobes.
  - reusable by the receiver.

Test Plan:
- Reset values: assert r_reset for 3 clocks during IDLE -> tx_serial = 1, tx_ready = 1, tx_busy = 0, tx_done = 0 on every cycle.
- Single frame: CLK_DIV = 2, OVERSAMPLE = 16, send 0xA5 -> tx_serial bits 0,1,0,1,0,0,1,0,1,1, each exactly 32 clocks. tx_done pulses once, 320 clocks after start-bit onset.
- Parity: PARITY_EN = 1, send 0xA5 -> parity bit 0 (even) / 1 (PARITY_ODD = 1). Send 0x01 even -> parity bit 1. Frame = 11 bits.
- Back-to-back with STOP_BITS = 2: tx_valid held high with 0x00 then 0xFF -> second start bit begins the clock after the first tx_done. Stop segment is exactly 64 clocks, and tx_ready is high only on the tx_done cycle.
- Reset mid-frame: r_reset asserted during data bit 3 of 0x55 -> tx_serial = 1 next clock, no tx_done. A new word accepted afterward produces a clean full frame.
- Loopback: drive tx_serial into the team's 16x receiver for 0x00, 0xFF, 0x3C -> receiver outputs identical bytes with its ready asserted once per frame.
